// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl
//   Match sequencer for a two-player pong game. Tracks scores, hands the
//   serve to the player who just lost a point, pauses between points and
//   declares a winner once a player reaches WIN_SCORE.
//
// Parameters
//   WIN_SCORE    points needed to win (1..9)
//   PAUSE_TICKS  TICK pulses spent between points (0 is treated as 1)
//
// Ports
//   CLK         in   system clock, rising edge
//   RSTn        in   asynchronous active-low reset
//   TICK        in   one-cycle game-tick pulse
//   START       in   raw push-button level, asynchronous to CLK
//   MISS1       in   ball parked past bar 1 (point to player 2)
//   MISS2       in   ball parked past bar 2 (point to player 1)
//   BALL_EN     out  ball-motion enable
//   SERVE       out  one-cycle pulse: re-place ball on the serving bar
//   SERVE_SIDE  out  serving player, 0 = bar 1, 1 = bar 2
//   SCORE1/2    out  binary scores 0..9
//   SCORE_DISP  out  SCORE1*100 + SCORE2 for the 7-segment converter
//   WINNER      out  0 = none, 1 = player 1, 2 = player 2
//   STATE       out  current state encoding (debug)
// ---------------------------------------------------------------------------
module pong_match_ctrl #(
    parameter logic [3:0] WIN_SCORE   = 4'd5,
    parameter logic [7:0] PAUSE_TICKS = 8'd16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        TICK,
    input  logic        START,
    input  logic        MISS1,
    input  logic        MISS2,
    output logic        BALL_EN,
    output logic        SERVE,
    output logic        SERVE_SIDE,
    output logic [3:0]  SCORE1,
    output logic [3:0]  SCORE2,
    output logic [13:0] SCORE_DISP,
    output logic [1:0]  WINNER,
    output logic [2:0]  STATE
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [7:0] PAUSE_LOAD = (PAUSE_TICKS == 8'd0) ? 8'd1 : PAUSE_TICKS;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd9 : v + 4'd1;
    endfunction

    function automatic logic [13:0] disp_of(input logic [3:0] s1, input logic [3:0] s2);
        return 14'(s1) * 14'd100 + 14'(s2);
    endfunction

    logic [2:0] state;
    logic [2:0] next_state;

    // start_p0/p1 form the synchronizer, start_p2 is the edge-detect history
    logic start_p0, start_p1, start_p2;
    logic miss1_p0, miss2_p0;
    logic start_edge, miss1_edge, miss2_edge;

    logic [7:0] pause_cnt;
    logic [7:0] pause_cnt_d;
    logic       ball_en_d, serve_d, serve_side_d;
    logic [3:0] score1_d, score2_d;
    logic [1:0] winner_d;
    logic       score_win;

    // ---- input conditioning stage ----
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            start_p0 <= 1'b0;
            start_p1 <= 1'b0;
            start_p2 <= 1'b0;
            miss1_p0 <= 1'b0;
            miss2_p0 <= 1'b0;
        end else begin
            start_p0 <= START;
            start_p1 <= start_p0;
            start_p2 <= start_p1;
            // history flops track the level in every state, so a level that
            // rose outside PLAY cannot score when PLAY is later entered
            miss1_p0 <= MISS1;
            miss2_p0 <= MISS2;
        end
    end

    assign start_edge = start_p1 & ~start_p2;
    assign miss1_edge = MISS1 & ~miss1_p0;
    assign miss2_edge = MISS2 & ~miss2_p0;
    assign score_win  = (SCORE1 == WIN_SCORE) || (SCORE2 == WIN_SCORE);

    // ---- state register ----
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign STATE = state;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start_edge) next_state = ST_SERVE;
            ST_SERVE: next_state = ST_PLAY;
            ST_PLAY:  if (miss1_edge || miss2_edge) next_state = ST_POINT;
            ST_POINT: begin
                // pause_cnt <= 1 means this TICK takes the counter to zero
                if (TICK && (pause_cnt <= 8'd1)) begin
                    next_state = score_win ? ST_OVER : ST_SERVE;
                end
            end
            ST_OVER:  if (start_edge) next_state = ST_SERVE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; BALL_EN/SERVE are decoded from
    // next_state so they line up with STATE in the same cycle.
    always_comb begin
        ball_en_d    = (next_state == ST_PLAY);
        serve_d      = (next_state == ST_SERVE);
        serve_side_d = SERVE_SIDE;
        score1_d     = SCORE1;
        score2_d     = SCORE2;
        winner_d     = WINNER;
        pause_cnt_d  = pause_cnt;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    score1_d     = 4'd0;
                    score2_d     = 4'd0;
                    winner_d     = 2'd0;
                    serve_side_d = 1'b0;
                end
            end
            ST_PLAY: begin
                // MISS1 wins a tie; a simultaneous MISS2 edge is dropped
                if (miss1_edge) begin
                    score2_d     = sat_inc(SCORE2);
                    serve_side_d = 1'b0;
                    pause_cnt_d  = PAUSE_LOAD;
                end else if (miss2_edge) begin
                    score1_d     = sat_inc(SCORE1);
                    serve_side_d = 1'b1;
                    pause_cnt_d  = PAUSE_LOAD;
                end
            end
            ST_POINT: begin
                if (TICK && (pause_cnt != 8'd0)) begin
                    pause_cnt_d = pause_cnt - 8'd1;
                end
                if (next_state == ST_OVER) begin
                    winner_d = (SCORE1 == WIN_SCORE) ? 2'd1 : 2'd2;
                end
            end
            default: ;
        endcase
    end

    // ---- output register stage ----
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            BALL_EN    <= 1'b0;
            SERVE      <= 1'b0;
            SERVE_SIDE <= 1'b0;
            SCORE1     <= 4'd0;
            SCORE2     <= 4'd0;
            SCORE_DISP <= 14'd0;
            WINNER     <= 2'd0;
            pause_cnt  <= 8'd0;
        end else begin
            BALL_EN    <= ball_en_d;
            SERVE      <= serve_d;
            SERVE_SIDE <= serve_side_d;
            SCORE1     <= score1_d;
            SCORE2     <= score2_d;
            SCORE_DISP <= disp_of(SCORE1, SCORE2);
            WINNER     <= winner_d;
            pause_cnt  <= pause_cnt_d;
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_match_ctrl
//   Self-checking bench for pong_match_ctrl (WIN_SCORE=3, PAUSE_TICKS=2).
//   A match-level reference model is stepped on every rising edge and all
//   outputs are compared one time unit later; directed scenarios add
//   fixed-value checks, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_pong_match_ctrl;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        TICK = 1'b0;
    logic        START = 1'b0;
    logic        MISS1 = 1'b0;
    logic        MISS2 = 1'b0;
    logic        BALL_EN, SERVE, SERVE_SIDE;
    logic [3:0]  SCORE1, SCORE2;
    logic [13:0] SCORE_DISP;
    logic [1:0]  WINNER;
    logic [2:0]  STATE;

    always #5 CLK = ~CLK;

    pong_match_ctrl #(.WIN_SCORE(4'd3), .PAUSE_TICKS(8'd2)) dut (
        .CLK(CLK), .RSTn(RSTn), .TICK(TICK), .START(START),
        .MISS1(MISS1), .MISS2(MISS2),
        .BALL_EN(BALL_EN), .SERVE(SERVE), .SERVE_SIDE(SERVE_SIDE),
        .SCORE1(SCORE1), .SCORE2(SCORE2), .SCORE_DISP(SCORE_DISP),
        .WINNER(WINNER), .STATE(STATE)
    );

    int checks = 0;
    int errors = 0;

    // reference model: match phase (0 idle,1 serve,2 play,3 point,4 over)
    int m_state, m_sc1, m_sc2, m_disp, m_win, m_side, m_ball, m_serve, m_pause;
    int st_hist[3];   // START samples of the last three edges, [0] newest
    int m1_prev, m2_prev;

    task automatic model_reset();
        m_state = 0; m_sc1 = 0; m_sc2 = 0; m_disp = 0; m_win = 0;
        m_side = 0; m_ball = 0; m_serve = 0; m_pause = 0;
        st_hist[0] = 0; st_hist[1] = 0; st_hist[2] = 0;
        m1_prev = 0; m2_prev = 0;
    endtask

    task automatic model_edge();
        int press, e1, e2, old_disp;
        if (!RSTn) begin
            model_reset();
        end else begin
            // a press first seen two edges ago and absent three edges ago
            press = (st_hist[1] == 1 && st_hist[2] == 0) ? 1 : 0;
            e1 = (MISS1 && m1_prev == 0) ? 1 : 0;
            e2 = (MISS2 && m2_prev == 0) ? 1 : 0;
            old_disp = m_sc1 * 100 + m_sc2;
            case (m_state)
                0, 4: if (press == 1) begin
                    m_sc1 = 0; m_sc2 = 0; m_win = 0; m_side = 0; m_state = 1;
                end
                1: m_state = 2;
                2: if (e1 == 1) begin
                    m_sc2 = (m_sc2 >= 9) ? 9 : m_sc2 + 1;
                    m_side = 0; m_state = 3; m_pause = 2;
                end else if (e2 == 1) begin
                    m_sc1 = (m_sc1 >= 9) ? 9 : m_sc1 + 1;
                    m_side = 1; m_state = 3; m_pause = 2;
                end
                3: if (TICK) begin
                    m_pause = m_pause - 1;
                    if (m_pause == 0) begin
                        if (m_sc1 == 3 || m_sc2 == 3) begin
                            m_state = 4;
                            m_win = (m_sc1 == 3) ? 1 : 2;
                        end else begin
                            m_state = 1;
                        end
                    end
                end
                default: m_state = 0;
            endcase
            m_ball  = (m_state == 2) ? 1 : 0;
            m_serve = (m_state == 1) ? 1 : 0;
            m_disp  = old_disp;
            st_hist[2] = st_hist[1];
            st_hist[1] = st_hist[0];
            st_hist[0] = START ? 1 : 0;
            m1_prev = MISS1 ? 1 : 0;
            m2_prev = MISS2 ? 1 : 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  32'(STATE),      m_state);
        chk({tag, ".ball"},   32'(BALL_EN),    m_ball);
        chk({tag, ".serve"},  32'(SERVE),      m_serve);
        chk({tag, ".side"},   32'(SERVE_SIDE), m_side);
        chk({tag, ".score1"}, 32'(SCORE1),     m_sc1);
        chk({tag, ".score2"}, 32'(SCORE2),     m_sc2);
        chk({tag, ".disp"},   32'(SCORE_DISP), m_disp);
        chk({tag, ".winner"}, 32'(WINNER),     m_win);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic tick();
        TICK = 1'b1;
        step();
        TICK = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        chk("reset_state", 32'(STATE), 0);
        step(); step();
        RSTn = 1'b1;
        step(); step();

        // START press: SERVE after k+2, PLAY after k+3
        START = 1'b1;
        step();                                  // edge k
        step();                                  // edge k+1
        chk("start_k1_state", 32'(STATE), 0);
        step();                                  // edge k+2
        chk("start_k2_state", 32'(STATE), 1);
        chk("start_k2_serve", 32'(SERVE), 1);
        step();                                  // edge k+3
        chk("start_k3_state", 32'(STATE), 2);
        chk("start_k3_ball",  32'(BALL_EN), 1);
        START = 1'b0;
        repeat (3) step();

        // START pressed during PLAY is ignored
        START = 1'b1;
        repeat (5) step();
        chk("play_start_state", 32'(STATE), 2);
        chk("play_start_sc1",   32'(SCORE1), 0);
        chk("play_start_sc2",   32'(SCORE2), 0);
        START = 1'b0;
        repeat (3) step();

        // MISS2 held for 50 cycles scores once
        MISS2 = 1'b1;
        step();
        chk("miss2_state", 32'(STATE), 3);
        chk("miss2_sc1",   32'(SCORE1), 1);
        chk("miss2_side",  32'(SERVE_SIDE), 1);
        for (int i = 0; i < 49; i++) begin
            TICK = (i == 3 || i == 6);
            step();
        end
        TICK = 1'b0;
        chk("miss2_held_state", 32'(STATE), 2);
        chk("miss2_held_sc1",   32'(SCORE1), 1);
        chk("miss2_held_disp",  32'(SCORE_DISP), 100);
        MISS2 = 1'b0;
        step();

        // simultaneous misses: only MISS1 counts
        MISS1 = 1'b1;
        MISS2 = 1'b1;
        step();
        chk("both_state", 32'(STATE), 3);
        chk("both_sc2",   32'(SCORE2), 1);
        chk("both_sc1",   32'(SCORE1), 1);
        chk("both_side",  32'(SERVE_SIDE), 0);
        tick(); tick(); step();
        MISS1 = 1'b0;
        MISS2 = 1'b0;
        step();

        // reset in POINT after one TICK
        MISS1 = 1'b1;
        step();
        chk("pt_state", 32'(STATE), 3);
        tick();
        chk("pt_tick_state", 32'(STATE), 3);
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_async_sc2", 32'(SCORE2), 0);
        START = 1'b1; step();
        START = 1'b0; step();
        START = 1'b1; step();
        START = 1'b0; step();
        MISS1 = 1'b0;
        step();
        RSTn = 1'b1;
        repeat (6) step();
        chk("rst_release_state", 32'(STATE), 0);

        // full match won by player 2
        START = 1'b1;
        repeat (4) step();
        START = 1'b0;
        step();
        for (int n = 0; n < 3; n++) begin
            MISS1 = 1'b1; step();
            MISS1 = 1'b0; step();
            tick(); tick();
            if (n < 2) step();
        end
        chk("over_state",  32'(STATE), 4);
        chk("over_winner", 32'(WINNER), 2);
        chk("over_disp",   32'(SCORE_DISP), 3);
        chk("over_ball",   32'(BALL_EN), 0);
        chk("over_sc2",    32'(SCORE2), 3);
        START = 1'b1;
        repeat (3) step();
        chk("restart_state",  32'(STATE), 1);
        chk("restart_sc1",    32'(SCORE1), 0);
        chk("restart_sc2",    32'(SCORE2), 0);
        chk("restart_winner", 32'(WINNER), 0);
        START = 1'b0;
        step();

        // randomized play
        for (int c = 0; c < 1500; c++) begin
            TICK = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) MISS1 = ~MISS1;
            if ($urandom_range(0, 9) == 0) MISS2 = ~MISS2;
            if ($urandom_range(0, 19) == 0) START = ~START;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 4'd5, points needed to win; legal range 1..9.
REQ-002 SHALL have parameter PAUSE_TICKS, default 8'd16, TICK pulses spent in POINT; value 0 behaves as 1.
REQ-003 SHALL have port CLK  in  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port TICK  in  1  one-cycle game-tick pulse from the ball-speed prescaler.
REQ-006 SHALL have port START  in  1  raw push-button level; asynchronous to CLK.
REQ-007 SHALL have port MISS1  in  1  synchronous level, high while the ball is parked past bar 1 (point to player 2).
REQ-008 SHALL have port MISS2  in  1  synchronous level, high while the ball is parked past bar 2 (point to player 1).
REQ-009 SHALL have port BALL_EN  out  1  ball-motion enable for the ball datapath.
REQ-010 SHALL have port SERVE  out  1  one-cycle pulse telling the datapath to re-place the ball on the serving bar.
REQ-011 SHALL have port SERVE_SIDE  out  1  serving player: 0 = bar 1, 1 = bar 2.
REQ-012 SHALL have ports SCORE1 and SCORE2  out  4 each  binary scores, 0..9.
REQ-013 SHALL have port SCORE_DISP  out  14  SCORE1*100 + SCORE2, for the 14-bit 7-segment converter.
REQ-014 SHALL have port WINNER  out  2  0 = none, 1 = player 1, 2 = player 2.
REQ-015 SHALL have port STATE  out  3  current state encoding, for debug.

Function
REQ-016 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; encodings 5..7 SHALL return to IDLE on the next edge.
REQ-017 SHALL pass START through a 2-flop synchronizer and rising-edge detect it; START high first sampled at edge k SHALL produce a transition at edge k+2.
REQ-018 SHALL rising-edge detect MISS1/MISS2 with one history flop each, without a synchronizer; a held level SHALL score exactly once.
REQ-019 IDLE: BALL_EN=0; on a START edge, clear scores and WINNER, set SERVE_SIDE=0, and go to SERVE.
REQ-020 SERVE: lasts exactly one cycle with SERVE=1 and BALL_EN=0, then goes to PLAY.
REQ-021 PLAY: BALL_EN=1. A MISS1 edge SHALL increment SCORE2 and set SERVE_SIDE=0; a MISS2 edge SHALL increment SCORE1 and set SERVE_SIDE=1. Either SHALL go to POINT on the same edge.
REQ-022 Simultaneous MISS1 and MISS2 edges: only MISS1 is honoured, and MISS2 is discarded.
REQ-023 MISS edges outside PLAY SHALL be ignored and SHALL NOT update the history-flop-based scoring later.
REQ-024 POINT: BALL_EN=0; a pause counter is loaded with max(PAUSE_TICKS,1) on entry and decrements on each TICK. The TICK that brings it to 0 exits to OVER if SCORE1 or SCORE2 equals WIN_SCORE, else to SERVE.
REQ-025 OVER: BALL_EN=0; WINNER = 1 if SCORE1==WIN_SCORE, else 2. A START edge clears scores and WINNER, sets SERVE_SIDE=0, and goes to SERVE.
REQ-026 START edges in SERVE, PLAY and POINT SHALL be ignored.
REQ-027 Scores SHALL saturate at 9 and never wrap.
REQ-028 SCORE_DISP SHALL be registered and reflect new scores one cycle after they change; the maximum is 909, which fits in 14 bits.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 RSTn low SHALL immediately force: state IDLE, BALL_EN=0, SERVE=0, SERVE_SIDE=0, SCORE1=SCORE2=0, SCORE_DISP=0, WINNER=0, pause counter 0, and all synchronizer and history flops 0.
REQ-031 Reset asserted mid-PLAY or mid-POINT SHALL abandon the match; after release the block stays in IDLE until a START edge.

Verification (bench: WIN_SCORE=3, PAUSE_TICKS=2)
REQ-032 Press START high at edge k -> STATE=1 and SERVE=1 after edge k+2; STATE=2 and BALL_EN=1 after edge k+3.
REQ-033 In PLAY, MISS2 held high for 50 cycles -> SCORE1=1 once, SERVE_SIDE=1, STATE=3; after 2 TICKs STATE=1, then 2; SCORE_DISP=100.
REQ-034 In PLAY, MISS1 and MISS2 rise on the same cycle -> SCORE2 increments, SCORE1 is unchanged, SERVE_SIDE=0.
REQ-035 Three MISS1 edges, each separated by the pause -> SCORE2=3; after 2 TICKs STATE=4, WINNER=2, SCORE_DISP=3, BALL_EN=0; then a START edge -> STATE=1, scores 0, WINNER=0.
REQ-036 In POINT with 1 TICK seen, pulse RSTn low -> all outputs go to reset values asynchronously; START pulses before the release have no effect.
REQ-037 In PLAY, press START -> no state change and no score change.
